// File: rtl/priv_mode_pkg.sv
// Shared privilege-mode types and the xRET/dcsr target legaliser.
// Encoding: U=00, S=01, M=11; 10 is reserved and never held in a register.
package priv_mode_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_level_t;

    typedef enum logic {
        RUN   = 1'b0,
        DEBUG = 1'b1
    } dbg_state_e;

    localparam logic [4:0] CAUSE_W = 5'd5;

    // Map a raw 2-bit mode onto the nearest implemented mode.
    function automatic priv_level_t legalize_priv(
        input logic [1:0] p,
        input logic       has_s,
        input logic       has_u
    );
        priv_level_t r;
        case (p)
            2'b11:   r = PRIV_M;
            2'b01:   r = has_s ? PRIV_S : (has_u ? PRIV_U : PRIV_M);
            default: r = has_u ? PRIV_U : PRIV_M;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/priv_mode_hart.sv
// One hart's privilege register: trap/xRET priority mux, M/S delegation, change pulse.
// Optional debug-mode FSM and dcsr.prv register when PRIV_DEBUG_MODE_EN is defined.
module priv_mode_hart
    import priv_mode_pkg::*;
#(
    parameter bit HAS_S = 1'b1,
    parameter bit HAS_U = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_i,
    input  logic        trap_is_intr_i,
    input  logic [4:0]  trap_cause_i,
    input  logic [31:0] medeleg_i,
    input  logic [31:0] mideleg_i,
    input  logic        mret_i,
    input  logic        sret_i,
    input  logic [1:0]  mpp_i,
    input  logic        spp_i,
    input  logic        mprv_i,
    output logic [1:0]  curr_priv_o,
    output logic [1:0]  eff_data_priv_o,
    output logic        trap_to_s_o,
    output logic        priv_chg_o
`ifdef PRIV_DEBUG_MODE_EN
    ,
    input  logic        debug_req_i,
    input  logic        dret_i,
    input  logic        dcsr_prv_we_i,
    input  logic [1:0]  dcsr_prv_wdata_i,
    output logic        debug_mode_o,
    output logic [1:0]  dcsr_prv_o
`endif
);

    priv_level_t priv_q, priv_d;
    priv_level_t arch_next;
    logic        chg_q, chg_d;
    logic        deleg_bit;
    logic        trap_to_s;

    assign deleg_bit = trap_is_intr_i ? mideleg_i[trap_cause_i] : medeleg_i[trap_cause_i];
    // Traps taken from M are never delegated downwards.
    assign trap_to_s = HAS_S && trap_i && (priv_q != PRIV_M) && deleg_bit;

    always_comb begin
        arch_next = priv_q;
        if (trap_i) begin
            arch_next = trap_to_s ? PRIV_S : PRIV_M;
        end else if (mret_i) begin
            arch_next = legalize_priv(mpp_i, HAS_S, HAS_U);
        end else if (sret_i && (priv_q != PRIV_U) && HAS_S) begin
            arch_next = spp_i ? PRIV_S : PRIV_U;
        end
    end

`ifdef PRIV_DEBUG_MODE_EN
    dbg_state_e  state_q, state_d;
    priv_level_t dcsr_q, dcsr_d;

    always_comb begin
        priv_d  = priv_q;
        state_d = state_q;
        dcsr_d  = dcsr_q;
        if (dcsr_prv_we_i) begin
            dcsr_d = legalize_priv(dcsr_prv_wdata_i, HAS_S, HAS_U);
        end
        case (state_q)
            RUN: begin
                if (debug_req_i) begin
                    dcsr_d  = priv_q;
                    priv_d  = PRIV_M;
                    state_d = DEBUG;
                end else begin
                    priv_d = arch_next;
                end
            end
            DEBUG: begin
                // A same-cycle dcsr write is the return target.
                if (dret_i) begin
                    priv_d  = legalize_priv(dcsr_d, HAS_S, HAS_U);
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        chg_d = (priv_d != priv_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            dcsr_q  <= PRIV_M;
        end else begin
            state_q <= state_d;
            dcsr_q  <= dcsr_d;
        end
    end

    assign debug_mode_o = (state_q == DEBUG);
    assign dcsr_prv_o   = dcsr_q;
`else
    always_comb begin
        priv_d = arch_next;
        chg_d  = (arch_next != priv_q);
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            priv_q <= PRIV_M;
            chg_q  <= 1'b0;
        end else begin
            priv_q <= priv_d;
            chg_q  <= chg_d;
        end
    end

    assign curr_priv_o     = priv_q;
    assign eff_data_priv_o = mprv_i ? legalize_priv(mpp_i, HAS_S, HAS_U) : priv_q;
    assign trap_to_s_o     = trap_to_s;
    assign priv_chg_o      = chg_q;

endmodule

// File: rtl/priv_mode_ctrl.sv
// Multi-hart privilege-mode controller: one priv_mode_hart per hart, top only slices buses.
// Debug-mode support is compiled in with PRIV_DEBUG_MODE_EN.
module priv_mode_ctrl
    import priv_mode_pkg::*;
#(
    parameter int NUM_HARTS = 1,
    parameter bit HAS_S     = 1'b1,
    parameter bit HAS_U     = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_HARTS-1:0]   trap_i,
    input  logic [NUM_HARTS-1:0]   trap_is_intr_i,
    input  logic [NUM_HARTS*5-1:0] trap_cause_i,
    input  logic [NUM_HARTS*32-1:0] medeleg_i,
    input  logic [NUM_HARTS*32-1:0] mideleg_i,
    input  logic [NUM_HARTS-1:0]   mret_i,
    input  logic [NUM_HARTS-1:0]   sret_i,
    input  logic [NUM_HARTS*2-1:0] mpp_i,
    input  logic [NUM_HARTS-1:0]   spp_i,
    input  logic [NUM_HARTS-1:0]   mprv_i,
    output logic [NUM_HARTS*2-1:0] curr_priv_o,
    output logic [NUM_HARTS*2-1:0] eff_data_priv_o,
    output logic [NUM_HARTS-1:0]   trap_to_s_o,
    output logic [NUM_HARTS-1:0]   priv_chg_o
`ifdef PRIV_DEBUG_MODE_EN
    ,
    input  logic [NUM_HARTS-1:0]   debug_req_i,
    input  logic [NUM_HARTS-1:0]   dret_i,
    input  logic [NUM_HARTS-1:0]   dcsr_prv_we_i,
    input  logic [NUM_HARTS*2-1:0] dcsr_prv_wdata_i,
    output logic [NUM_HARTS-1:0]   debug_mode_o,
    output logic [NUM_HARTS*2-1:0] dcsr_prv_o
`endif
);

    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
        priv_mode_hart #(
            .HAS_S (HAS_S),
            .HAS_U (HAS_U)
        ) u_hart (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .trap_i          (trap_i[gi]),
            .trap_is_intr_i  (trap_is_intr_i[gi]),
            .trap_cause_i    (trap_cause_i[gi*5 +: 5]),
            .medeleg_i       (medeleg_i[gi*32 +: 32]),
            .mideleg_i       (mideleg_i[gi*32 +: 32]),
            .mret_i          (mret_i[gi]),
            .sret_i          (sret_i[gi]),
            .mpp_i           (mpp_i[gi*2 +: 2]),
            .spp_i           (spp_i[gi]),
            .mprv_i          (mprv_i[gi]),
            .curr_priv_o     (curr_priv_o[gi*2 +: 2]),
            .eff_data_priv_o (eff_data_priv_o[gi*2 +: 2]),
            .trap_to_s_o     (trap_to_s_o[gi]),
            .priv_chg_o      (priv_chg_o[gi])
`ifdef PRIV_DEBUG_MODE_EN
            ,
            .debug_req_i     (debug_req_i[gi]),
            .dret_i          (dret_i[gi]),
            .dcsr_prv_we_i   (dcsr_prv_we_i[gi]),
            .dcsr_prv_wdata_i(dcsr_prv_wdata_i[gi*2 +: 2]),
            .debug_mode_o    (debug_mode_o[gi]),
            .dcsr_prv_o      (dcsr_prv_o[gi*2 +: 2])
`endif
        );
    end

endmodule

// File: tb/tb_priv_mode_ctrl.sv
// Bench: two-hart full-featured instance plus S-less and machine-only single-hart instances.
module tb_priv_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  trap = '0, intr = '0, mret = '0, sret = '0, spp = '0, mprv = '0;
    logic [9:0]  cause = '0;
    logic [3:0]  mpp = '0;
    logic [63:0] medeleg = {2{32'h0000_0100}};
    logic [63:0] mideleg = {2{32'h0000_0020}};
    logic [3:0]  curr, eff;
    logic [1:0]  tts, chg;
    logic [1:0]  ns_curr, ns_eff, mo_curr, mo_eff;
    logic        ns_tts, ns_chg, mo_tts, mo_chg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef PRIV_DEBUG_MODE_EN
    logic [1:0] dbg_req = '0, dret = '0, dwe = '0, dbg_mode;
    logic [3:0] dwdata = '0, dcsr;
    logic       ns_dm, mo_dm;
    logic [1:0] ns_dcsr, mo_dcsr;
`endif

    priv_mode_ctrl #(.NUM_HARTS(2), .HAS_S(1'b1), .HAS_U(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .trap_i(trap), .trap_is_intr_i(intr), .trap_cause_i(cause),
        .medeleg_i(medeleg), .mideleg_i(mideleg), .mret_i(mret), .sret_i(sret), .mpp_i(mpp),
        .spp_i(spp), .mprv_i(mprv), .curr_priv_o(curr), .eff_data_priv_o(eff),
        .trap_to_s_o(tts), .priv_chg_o(chg)
`ifdef PRIV_DEBUG_MODE_EN
        , .debug_req_i(dbg_req), .dret_i(dret), .dcsr_prv_we_i(dwe), .dcsr_prv_wdata_i(dwdata),
        .debug_mode_o(dbg_mode), .dcsr_prv_o(dcsr)
`endif
    );

    priv_mode_ctrl #(.NUM_HARTS(1), .HAS_S(1'b0), .HAS_U(1'b1)) dut_ns (
        .clk_i(clk), .rst_i(rst), .trap_i(trap[0]), .trap_is_intr_i(intr[0]), .trap_cause_i(cause[4:0]),
        .medeleg_i(medeleg[31:0]), .mideleg_i(mideleg[31:0]), .mret_i(mret[0]), .sret_i(sret[0]),
        .mpp_i(mpp[1:0]), .spp_i(spp[0]), .mprv_i(mprv[0]), .curr_priv_o(ns_curr),
        .eff_data_priv_o(ns_eff), .trap_to_s_o(ns_tts), .priv_chg_o(ns_chg)
`ifdef PRIV_DEBUG_MODE_EN
        , .debug_req_i(1'b0), .dret_i(1'b0), .dcsr_prv_we_i(1'b0), .dcsr_prv_wdata_i(2'b00),
        .debug_mode_o(ns_dm), .dcsr_prv_o(ns_dcsr)
`endif
    );

    priv_mode_ctrl #(.NUM_HARTS(1), .HAS_S(1'b0), .HAS_U(1'b0)) dut_mo (
        .clk_i(clk), .rst_i(rst), .trap_i(trap[0]), .trap_is_intr_i(intr[0]), .trap_cause_i(cause[4:0]),
        .medeleg_i(medeleg[31:0]), .mideleg_i(mideleg[31:0]), .mret_i(mret[0]), .sret_i(sret[0]),
        .mpp_i(mpp[1:0]), .spp_i(spp[0]), .mprv_i(mprv[0]), .curr_priv_o(mo_curr),
        .eff_data_priv_o(mo_eff), .trap_to_s_o(mo_tts), .priv_chg_o(mo_chg)
`ifdef PRIV_DEBUG_MODE_EN
        , .debug_req_i(1'b0), .dret_i(1'b0), .dcsr_prv_we_i(1'b0), .dcsr_prv_wdata_i(2'b00),
        .debug_mode_o(mo_dm), .dcsr_prv_o(mo_dcsr)
`endif
    );

    typedef struct packed {
        logic [1:0] trap, intr;
        logic [9:0] cause;
        logic [1:0] mret, sret;
        logic [3:0] mpp;
        logic [1:0] spp, mprv;
        logic [1:0] tts;
        logic [3:0] eff, priv;
        logic [1:0] chg, ns, mo;
    } vec_t;

    typedef struct packed {
        logic [3:0] priv;
        logic [1:0] chg, ns, mo;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic [1:0] t, input logic [1:0] it, input logic [9:0] c,
        input logic [1:0] mr, input logic [1:0] sr, input logic [3:0] mp,
        input logic [1:0] sp, input logic [1:0] mv, input logic [1:0] e_tts,
        input logic [3:0] e_eff, input logic [3:0] e_priv, input logic [1:0] e_chg,
        input logic [1:0] e_ns, input logic [1:0] e_mo);
        vec_t v;
        v.trap = t; v.intr = it; v.cause = c; v.mret = mr; v.sret = sr; v.mpp = mp;
        v.spp = sp; v.mprv = mv; v.tts = e_tts; v.eff = e_eff; v.priv = e_priv;
        v.chg = e_chg; v.ns = e_ns; v.mo = e_mo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        trap = '0; intr = '0; cause = '0; mret = '0; sret = '0; mpp = '0; spp = '0; mprv = '0;
    endtask

    initial begin
        exp_t e;
        // Fields: trap intr cause mret sret mpp spp mprv | tts eff priv chg ns mo
        vecs[0]  = mk(2'b00, 2'b00, 10'h000,     2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b1111, 4'b1111, 2'b00, 2'b11, 2'b11);
        vecs[1]  = mk(2'b01, 2'b00, {5'd0,5'd8}, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b1111, 4'b1111, 2'b00, 2'b11, 2'b11);
        vecs[2]  = mk(2'b00, 2'b00, 10'h000,     2'b01, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b00, 4'b1111, 4'b1100, 2'b01, 2'b00, 2'b11);
        vecs[3]  = mk(2'b00, 2'b00, 10'h000,     2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b1100, 4'b1100, 2'b00, 2'b00, 2'b11);
        vecs[4]  = mk(2'b01, 2'b00, {5'd0,5'd8}, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b01, 4'b1100, 4'b1101, 2'b01, 2'b11, 2'b11);
        vecs[5]  = mk(2'b01, 2'b00, {5'd0,5'd8}, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b01, 4'b1101, 4'b1101, 2'b00, 2'b11, 2'b11);
        vecs[6]  = mk(2'b01, 2'b01, {5'd0,5'd5}, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b01, 4'b1101, 4'b1101, 2'b00, 2'b11, 2'b11);
        vecs[7]  = mk(2'b01, 2'b01, {5'd0,5'd8}, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b1101, 4'b1111, 2'b01, 2'b11, 2'b11);
        vecs[8]  = mk(2'b00, 2'b00, 10'h000,     2'b01, 2'b10, 4'b0001, 2'b10, 2'b00, 2'b00, 4'b1111, 4'b0101, 2'b11, 2'b00, 2'b11);
        vecs[9]  = mk(2'b10, 2'b00, {5'd3,5'd0}, 2'b10, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0101, 4'b1101, 2'b10, 2'b00, 2'b11);
        vecs[10] = mk(2'b00, 2'b00, 10'h000,     2'b00, 2'b00, 4'b0010, 2'b00, 2'b11, 2'b00, 4'b0000, 4'b1101, 2'b00, 2'b00, 2'b11);
        vecs[11] = mk(2'b00, 2'b00, 10'h000,     2'b00, 2'b01, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b1101, 4'b1100, 2'b01, 2'b00, 2'b11);
        vecs[12] = mk(2'b00, 2'b00, 10'h000,     2'b10, 2'b11, 4'b0000, 2'b11, 2'b00, 2'b00, 4'b1100, 4'b0000, 2'b10, 2'b00, 2'b11);
        vecs[13] = mk(2'b11, 2'b01, {5'd8,5'd8}, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b10, 4'b0000, 4'b0111, 2'b11, 2'b11, 2'b11);
        vecs[14] = mk(2'b00, 2'b00, 10'h000,     2'b01, 2'b00, 4'b0011, 2'b00, 2'b00, 2'b00, 4'b0111, 4'b0111, 2'b00, 2'b11, 2'b11);
        vecs[15] = mk(2'b00, 2'b00, 10'h000,     2'b01, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0111, 4'b0100, 2'b01, 2'b00, 2'b11);
        vecs[16] = mk(2'b00, 2'b00, 10'h000,     2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0100, 4'b0100, 2'b00, 2'b00, 2'b11);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_curr", {4'h0, curr}, 8'h0F);
        chk("reset_chg", {6'h0, chg}, 8'h00);
        chk("reset_eff", {4'h0, eff}, 8'h0F);
        chk("reset_small", {4'h0, ns_curr, mo_curr}, 8'h0F);
        $display("reset released: curr=%b chg=%b eff=%b", curr, chg, eff);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            trap = vecs[i].trap; intr = vecs[i].intr; cause = vecs[i].cause;
            mret = vecs[i].mret; sret = vecs[i].sret; mpp = vecs[i].mpp;
            spp = vecs[i].spp; mprv = vecs[i].mprv;
            #1;
            chk($sformatf("v%0d_tts", i), {6'h0, tts}, {6'h0, vecs[i].tts});
            chk($sformatf("v%0d_eff", i), {4'h0, eff}, {4'h0, vecs[i].eff});
            sb.push_back({vecs[i].priv, vecs[i].chg, vecs[i].ns, vecs[i].mo});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 8'h01, 8'h00);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_curr", i), {4'h0, curr}, {4'h0, e.priv});
                chk($sformatf("v%0d_chg", i), {6'h0, chg}, {6'h0, e.chg});
                chk($sformatf("v%0d_small", i), {4'h0, ns_curr, mo_curr}, {4'h0, e.ns, e.mo});
            end
            $display("vec %0d: trap=%b mret=%b sret=%b mpp=%b -> curr=%b chg=%b tts=%b", i, trap, mret, sret, mpp, curr, chg, tts);
        end

        // Asynchronous reset mid-operation with pending events
        @(negedge clk);
        trap = 2'b11; cause = {5'd8, 5'd8}; rst = 1'b1;
        #1;
        chk("async_rst_curr", {4'h0, curr}, 8'h0F);
        chk("async_rst_chg", {6'h0, chg}, 8'h00);
        chk("async_rst_small", {4'h0, ns_curr, mo_curr}, 8'h0F);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("post_rst_curr", {4'h0, curr}, 8'h0F);
        chk("post_rst_chg", {6'h0, chg}, 8'h00);
        $display("async reset: curr=%b chg=%b", curr, chg);

`ifdef PRIV_DEBUG_MODE_EN
        @(negedge clk); mret = 2'b01; mpp = 4'b0000;
        @(negedge clk); mret = 2'b00; dbg_req = 2'b01;
        @(posedge clk); #1;
        chk("dbg_enter_mode", {6'h0, dbg_mode}, 8'h01);
        chk("dbg_enter_curr", {4'h0, curr}, 8'h0F);
        chk("dbg_enter_dcsr", {4'h0, dcsr}, 8'h0C);
        @(negedge clk); dbg_req = 2'b00; trap = 2'b01; cause = {5'd0, 5'd8};
        @(posedge clk); #1;
        chk("dbg_trap_curr", {4'h0, curr}, 8'h0F);
        chk("dbg_trap_mode", {6'h0, dbg_mode}, 8'h01);
        @(negedge clk); trap = 2'b00; dwe = 2'b01; dwdata = 4'b0010; dret = 2'b01;
        @(posedge clk); #1;
        chk("dret_curr", {4'h0, curr}, 8'h0C);
        chk("dret_mode", {6'h0, dbg_mode}, 8'h00);
        @(negedge clk); dwe = 2'b00; dret = 2'b00; dbg_req = 2'b01;
        @(negedge clk); dbg_req = 2'b00; rst = 1'b1;
        #1;
        chk("dbg_rst_mode", {6'h0, dbg_mode}, 8'h00);
        chk("dbg_rst_curr", {4'h0, curr}, 8'h0F);
        @(negedge clk); rst = 1'b0;
        $display("debug sequence: mode=%b curr=%b dcsr=%b", dbg_mode, curr, dcsr);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
